// File: rtl/nps_inmem.sv
// nps_inmem: CPU-loaded frame buffer streamed out as a vo/fo/datao word stream.
// Optional frame repetition is enabled by defining NPS_INMEM_LOOP_EN.
module nps_inmem #(
  parameter int DATA_WIDTH = 24,
  parameter int DATA_NUM   = 300,
  parameter int ADR_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset_x,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADR_WIDTH:0]    len,
  input  logic [ADR_WIDTH-1:0]  cpu_adr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic                  cpu_wr,
`ifdef NPS_INMEM_LOOP_EN
  input  logic                  loop,
`endif
  output logic                  vo,
  output logic                  fo,
  output logic [DATA_WIDTH-1:0] datao,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  localparam logic [ADR_WIDTH:0] LP_NUM = (ADR_WIDTH+1)'(DATA_NUM);
  localparam logic [ADR_WIDTH:0] LP_ONE = (ADR_WIDTH+1)'(1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [DATA_NUM];
  logic [ADR_WIDTH:0]    r_rd_cnt;
  logic [ADR_WIDTH:0]    r_eff_len;
  logic [ADR_WIDTH:0]    w_eff_len;
  logic                  w_last;
  logic                  w_wr_en;
  logic                  w_loop;

`ifdef NPS_INMEM_LOOP_EN
  logic r_loop;
  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  always_comb begin
    w_eff_len = len;
    if (len == '0 || len > LP_NUM) w_eff_len = LP_NUM;
    w_last  = (r_rd_cnt == r_eff_len - LP_ONE);
    w_wr_en = cpu_wr && (r_state == IDLE) && ({1'b0, cpu_adr} < LP_NUM);
  end

  // Storage has no reset so it maps onto a plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[cpu_adr] <= cpu_data;
  end

  always_ff @(posedge clk) begin
    if (reset_x) begin
      r_state   <= IDLE;
      vo        <= 1'b0;
      fo        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      datao     <= '0;
      r_rd_cnt  <= '0;
      r_eff_len <= '0;
`ifdef NPS_INMEM_LOOP_EN
      r_loop    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          vo <= 1'b0;
          fo <= 1'b0;
          if (start) begin
            r_eff_len <= w_eff_len;
            r_rd_cnt  <= '0;
            busy      <= 1'b1;
            r_state   <= STREAM;
`ifdef NPS_INMEM_LOOP_EN
            r_loop    <= loop;
`endif
          end
        end
        STREAM: begin
          if (stop) begin
            // The word issued last cycle is already on datao; just close out.
            vo      <= 1'b0;
            fo      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= IDLE;
          end else begin
            datao <= r_mem[r_rd_cnt[ADR_WIDTH-1:0]];
            vo    <= 1'b1;
            fo    <= (r_rd_cnt == '0);
            if (w_last && w_loop) begin
              r_rd_cnt <= '0;
            end else begin
              r_rd_cnt <= r_rd_cnt + LP_ONE;
              if (w_last) r_state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          vo      <= 1'b0;
          fo      <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nps_inmem.sv
// Self-checking bench for nps_inmem: expected words are queued at start and matched against vo words.
module tb_nps_inmem;
  localparam int DW = 24;
  localparam int DN = 300;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset_x = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] cpu_adr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          cpu_wr = 1'b0;
`ifdef NPS_INMEM_LOOP_EN
  logic          loop = 1'b0;
`endif
  logic          vo, fo, busy, done;
  logic [DW-1:0] datao;

  nps_inmem #(.DATA_WIDTH(DW), .DATA_NUM(DN), .ADR_WIDTH(AW)) dut (
    .clk(clk), .reset_x(reset_x), .start(start), .stop(stop), .len(len),
    .cpu_adr(cpu_adr), .cpu_data(cpu_data), .cpu_wr(cpu_wr),
`ifdef NPS_INMEM_LOOP_EN
    .loop(loop),
`endif
    .vo(vo), .fo(fo), .datao(datao), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  logic [DW-1:0] model [DN];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  int fo_idx[$];
  int first_vo, last_vo, n_vo, n_fo_bad, busy_first, busy_last, n_busy, done_cyc, n_done;

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    cpu_wr = 1'b1; cpu_adr = a; cpu_data = d;
    @(posedge clk); #1;
    cpu_wr = 1'b0;
    if (a < AW'(DN)) model[a] = d;
  endtask

  // Returns just after edge T at which start was sampled.
  task automatic pulse_start(input logic [AW:0] l, input logic lp);
    @(posedge clk); #1;
    start = 1'b1; len = l;
`ifdef NPS_INMEM_LOOP_EN
    loop = lp;
`else
    if (lp) $display("loop request ignored in this build");
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_frame(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(model[k % DN]);
  endtask

  // Records one sample per cycle; cycle c is the cycle following edge T+c-1.
  task automatic collect(input int budget);
    first_vo = -1; last_vo = -1; n_vo = 0; n_fo_bad = 0;
    busy_first = -1; busy_last = -1; n_busy = 0; done_cyc = -1; n_done = 0;
    fo_idx.delete();
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (vo === 1'b1) begin
        if (n_vo == 0) first_vo = c;
        last_vo = c;
        obs_q.push_back(datao);
        if (fo === 1'b1) fo_idx.push_back(n_vo);
        n_vo++;
      end else if (fo !== 1'b0) n_fo_bad++;
      if (busy === 1'b1) begin
        if (n_busy == 0) busy_first = c;
        busy_last = c;
        n_busy++;
      end
      if (done === 1'b1) begin
        if (n_done == 0) done_cyc = c;
        n_done++;
      end
    end
  endtask

  task automatic drain(output int nbad);
    logic [DW-1:0] e;
    nbad = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) nbad++;
      else if (obs_q.pop_front() !== e) nbad++;
    end
    nbad += obs_q.size();
    obs_q.delete();
  endtask

  task automatic test_reset();
    reset_x = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (vo !== 1'b0) $display("FAIL rst_vo got %b want 0", vo); else n_pass++;
    n_chk++; if (fo !== 1'b0) $display("FAIL rst_fo got %b want 0", fo); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_chk++; if (datao !== '0) $display("FAIL rst_datao got %h want 0", datao); else n_pass++;
    #1 reset_x = 1'b0;
  endtask

  task automatic test_full_frame();
    int nbad;
    for (int i = 0; i < DN; i++) cpu_write(AW'(i), DW'(i + 'h100));
    pulse_start('0, 1'b0);
    push_frame(DN);
    collect(DN + 8);
    drain(nbad);
    n_chk++; if (n_vo !== DN) $display("FAIL full_nvo got %0d want %0d", n_vo, DN); else n_pass++;
    n_chk++; if (first_vo !== 2 || last_vo !== 301) $display("FAIL full_vo_span got %0d..%0d want 2..301", first_vo, last_vo); else n_pass++;
    n_chk++; if (fo_idx.size() !== 1 || fo_idx[0] !== 0 || n_fo_bad !== 0) $display("FAIL full_fo got %0d fo pulses want 1 at word 0", fo_idx.size()); else n_pass++;
    n_chk++; if (done_cyc !== 302 || n_done !== 1) $display("FAIL full_done got cyc %0d cnt %0d want cyc 302 cnt 1", done_cyc, n_done); else n_pass++;
    n_chk++; if (nbad !== 0) $display("FAIL full_data got %0d bad words want 0", nbad); else n_pass++;
  endtask

  task automatic test_short_frame();
    int nbad;
    for (int i = 0; i < 5; i++) cpu_write(AW'(i), DW'('hA0 + i));
    pulse_start(10'd5, 1'b0);
    push_frame(5);
    collect(12);
    drain(nbad);
    n_chk++; if (n_vo !== 5 || first_vo !== 2 || last_vo !== 6) $display("FAIL short_vo got %0d words %0d..%0d want 5 words 2..6", n_vo, first_vo, last_vo); else n_pass++;
    n_chk++; if (busy_first !== 1 || busy_last !== 6 || n_busy !== 6) $display("FAIL short_busy got %0d..%0d want 1..6", busy_first, busy_last); else n_pass++;
    n_chk++; if (done_cyc !== 7 || n_done !== 1) $display("FAIL short_done got cyc %0d cnt %0d want cyc 7 cnt 1", done_cyc, n_done); else n_pass++;
    n_chk++; if (nbad !== 0) $display("FAIL short_data got %0d bad words want 0", nbad); else n_pass++;
  endtask

  task automatic test_clamp();
    int nbad;
    pulse_start(10'd400, 1'b0);
    push_frame(DN);
    collect(DN + 6);
    drain(nbad);
    n_chk++; if (n_vo !== DN || done_cyc !== 302) $display("FAIL clamp_len got %0d words done %0d want %0d words done 302", n_vo, done_cyc, DN); else n_pass++;
    n_chk++; if (nbad !== 0) $display("FAIL clamp_data got %0d bad words want 0", nbad); else n_pass++;
    cpu_write(9'd300, 24'hDEAD00);
    collect(6);
    obs_q.delete();
    n_chk++; if (n_vo !== 0 || n_done !== 0) $display("FAIL oob_write got vo %0d done %0d want 0 0", n_vo, n_done); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int nbad;
    pulse_start(10'd10, 1'b0);
    push_frame(10);
    fork
      collect(16);
      begin
        repeat (3) @(posedge clk); #1;
        cpu_wr = 1'b1; cpu_adr = 9'd3; cpu_data = 24'hBADBAD; start = 1'b1; len = 10'd2;
        @(posedge clk); #1;
        cpu_wr = 1'b0; start = 1'b0;
      end
    join
    drain(nbad);
    n_chk++; if (n_vo !== 10 || n_done !== 1) $display("FAIL busy_ign got %0d words %0d done want 10 words 1 done", n_vo, n_done); else n_pass++;
    n_chk++; if (nbad !== 0) $display("FAIL busy_data got %0d bad words want 0", nbad); else n_pass++;
    pulse_start(10'd4, 1'b0);
    push_frame(4);
    collect(8);
    drain(nbad);
    n_chk++; if (nbad !== 0 || n_vo !== 4) $display("FAIL busy_wr_drop got %0d bad %0d words want 0 bad 4 words", nbad, n_vo); else n_pass++;
  endtask

  task automatic test_stop();
    int nbad;
    pulse_start(10'd10, 1'b0);
    push_frame(4);
    fork
      collect(10);
      begin
        repeat (4) @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
      end
    join
    drain(nbad);
    n_chk++; if (n_vo !== 4 || last_vo !== 5) $display("FAIL stop_words got %0d last %0d want 4 last 5", n_vo, last_vo); else n_pass++;
    n_chk++; if (done_cyc !== 6 || n_done !== 1) $display("FAIL stop_done got cyc %0d cnt %0d want cyc 6 cnt 1", done_cyc, n_done); else n_pass++;
    n_chk++; if (nbad !== 0) $display("FAIL stop_data got %0d bad words want 0", nbad); else n_pass++;
    pulse_start(10'd2, 1'b0);
    push_frame(2);
    collect(6);
    drain(nbad);
    n_chk++; if (n_vo !== 2 || fo_idx.size() !== 1 || nbad !== 0 || done_cyc !== 4) $display("FAIL after_stop got %0d words %0d fo %0d bad done %0d want 2 1 0 4", n_vo, fo_idx.size(), nbad, done_cyc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    pulse_start(10'd10, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (vo !== 1'b1) $display("FAIL mid_pre_vo got %b want 1", vo); else n_pass++;
    #1 reset_x = 1'b1;
    @(posedge clk); @(negedge clk);
    n_chk++; if ({vo, fo, busy, done} !== 4'b0000 || datao !== '0) $display("FAIL mid_rst got vfbd %b datao %h want 0000 0", {vo, fo, busy, done}, datao); else n_pass++;
    #1 reset_x = 1'b0;
    collect(6);
    obs_q.delete();
    n_chk++; if (n_vo !== 0 || n_busy !== 0) $display("FAIL mid_rst_idle got vo %0d busy %0d want 0 0", n_vo, n_busy); else n_pass++;
  endtask

`ifdef NPS_INMEM_LOOP_EN
  task automatic test_loop();
    int nbad;
    pulse_start(10'd3, 1'b1);
    push_frame(8);
    fork
      collect(14);
      begin
        repeat (8) @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
      end
    join
    drain(nbad);
    n_chk++; if (n_vo !== 8 || nbad !== 0) $display("FAIL loop_words got %0d words %0d bad want 8 0", n_vo, nbad); else n_pass++;
    n_chk++; if (fo_idx.size() !== 3 || fo_idx[1] !== 3 || fo_idx[2] !== 6) $display("FAIL loop_fo got %0d pulses want 3 at 0,3,6", fo_idx.size()); else n_pass++;
    n_chk++; if (n_done !== 1 || done_cyc !== 10) $display("FAIL loop_done got cyc %0d cnt %0d want cyc 10 cnt 1", done_cyc, n_done); else n_pass++;
    pulse_start(10'd3, 1'b1);
    repeat (6) @(posedge clk);
    #1 reset_x = 1'b1;
    @(posedge clk); @(negedge clk);
    n_chk++; if ({vo, fo, busy, done} !== 4'b0000 || datao !== '0) $display("FAIL loop_rst got vfbd %b datao %h want 0000 0", {vo, fo, busy, done}, datao); else n_pass++;
    #1 reset_x = 1'b0; loop = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_clamp();
    test_busy_ignore();
    test_stop();
    test_reset_mid();
`ifdef NPS_INMEM_LOOP_EN
    test_loop();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nps_inmem.md
Name: nps_inmem

Overview:
Input-side frame buffer that feeds the NPS output-capture stage.
- CPU loads up to DATA_NUM words through a simple write port.
- On a start pulse, the block streams a frame of len words as a one-word-per-cycle vo/fo/datao stream, which connects directly to the downstream vi/fi/datai.
- There is no backpressure; the downstream stage must accept every cycle.

Parameters:
DATA_WIDTH, 24, width of each data word
DATA_NUM, 300, memory depth in words; maximum frame length
ADR_WIDTH, 9, CPU/read address width; must satisfy 2^ADR_WIDTH >= DATA_NUM

Ports:
clk  input  1  clock, all logic on rising edge
reset_x  input  1  reset: synchronous and active-high
start  input  1  one-cycle pulse; begins a frame when idle
stop  input  1  abort current frame
len  input  ADR_WIDTH+1  frame length in words, sampled on accepted start
cpu_adr  input  ADR_WIDTH  CPU write address
cpu_data  input  DATA_WIDTH  CPU write data
cpu_wr  input  1  CPU write strobe
vo  output  1  output data valid
fo  output  1  frame flag; high with first word of frame only
datao  output  DATA_WIDTH  output data, registered
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse after the last word or an abort

Behaviour:
- Reset (reset_x=1 at a clk edge):
  - vo, fo, busy and done go to 0; datao goes to 0; state goes to IDLE; the read counter goes to 0.
  - Memory contents are not reset.
  - Reset mid-frame stops the stream at the next edge.
- Memory:
  - DATA_NUM x DATA_WIDTH, one CPU write port and one internal read port.
  - The read data is registered, so read latency is 1 cycle.
- CPU write:
  - When cpu_wr=1, state is IDLE and cpu_adr<DATA_NUM, mem[cpu_adr]<=cpu_data.
  - Writes while busy=1 are dropped.
  - Writes with cpu_adr>=DATA_NUM are dropped.
- Effective length eff_len:
  - len=0 gives DATA_NUM.
  - len>DATA_NUM gives DATA_NUM.
  - Otherwise eff_len=len.
- State machine states: IDLE, STREAM, FLUSH.
- IDLE:
  - start=1 at edge T: latch eff_len, set rd_cnt=0, busy<=1, go to STREAM.
  - start while not IDLE is ignored.
- STREAM:
  - Each cycle: issue read at rd_cnt, then rd_cnt<=rd_cnt+1.
  - Data for address k appears on datao with vo=1 one cycle after issue.
  - When issuing address eff_len-1, go to FLUSH.
- FLUSH (one cycle):
  - The last word is presented.
  - On the next edge: vo<=0, busy<=0, done<=1, go to IDLE.
- Timing for start accepted at edge T:
  - vo is high on cycles T+2 through T+1+eff_len (eff_len consecutive words, no gaps).
  - fo is high on T+2 only.
  - datao on cycle T+2+k equals mem[k].
  - done pulses on T+2+eff_len.
  - busy is high from T+1 through T+1+eff_len inclusive.
- stop:
  - stop=1 in STREAM or FLUSH: no new read is issued.
  - The word already in flight is still output with vo=1; the next cycle has vo=0, done=1 and state IDLE.
  - stop in IDLE has no effect.
  - If stop and start are both 1 in IDLE, start wins.
- Outputs:
  - fo=1 only when vo=1.
  - datao holds its last value when vo=0.
  - done asserts exactly once per accepted start, including on abort.
- Width: rd_cnt is ADR_WIDTH+1 bits; comparisons are unsigned; no wrap inside a frame.

Optional Feature:
Macro: NPS_INMEM_LOOP_EN
- Defined:
  - Adds input port loop (1 bit), sampled on the accepted start.
  - If latched loop=1, after issuing eff_len-1 the block restarts at address 0 on the next cycle with no gap cycle.
  - fo=1 on the first word of each repetition; done does not pulse between repetitions.
  - The loop ends only on stop, which behaves as specified above, or on reset.
- Not defined:
  - No loop port; each start produces exactly one frame.

Test Plan:
- Reset with vo/fo/busy/done probed -> all 0 and state IDLE; then CPU writes 300 words mem[i]=i+0x100, followed by start with len=0 -> 300 consecutive vo cycles, datao 0x100..0x22B, fo on the first only, done on T+302.
- Load mem[0..4]=0xA0..0xA4, start with len=5 at T -> vo on T+2..T+6 with datao A0..A4, busy on T+1..T+6, done on T+7.
- len=400 -> clamped to 300 words; cpu_wr to adr 300 -> mem unchanged and no stray vo.
- During a len=10 frame, assert cpu_wr to adr 3 and a second start -> both ignored; read-back via a new frame shows the old mem[3]; exactly one done pulse.
- stop on the 4th STREAM cycle of a len=10 frame -> 4 or 5 vo words (per the in-flight rule), then done; immediately issue start with len=2 -> 2 words, fo on the first.
- NPS_INMEM_LOOP_EN with loop=1, len=3 -> words 0,1,2,0,1,2,... with fo every 3rd word and no done; stop -> in-flight word is output, then done; reset_x mid-loop -> all outputs 0 next cycle.
